// File: rtl/dds_param_ctrl.sv
// dds_param_ctrl: stages phase increment, amplitude and shape from manual
// step pulses or a triangular frequency sweep, and commits them to the
// outputs either on every accumulator wrap or on every clock.
module dds_param_ctrl #(
  parameter int PHASE_W     = 13,
  parameter int AMP_W       = 11,
  parameter int PHASE_INIT  = 500,
  parameter int AMP_INIT    = 1200,
  parameter int AMP_MAX     = 2047,
  parameter int PHASE_STEP  = 10,
  parameter int AMP_STEP    = 50,
  parameter int SWEEP_MIN   = 100,
  parameter int SWEEP_MAX   = 4000,
  parameter int SWEEP_DIV   = 1000,
  parameter int SYNC_UPDATE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freq_up,
  input  logic               freq_dn,
  input  logic               amp_up,
  input  logic               amp_dn,
  input  logic               shape_next,
  input  logic               sweep_en,
  input  logic               phase_wrap,
  output logic [PHASE_W-1:0] phase_M,
  output logic [AMP_W-1:0]   signal_A,
  output logic [1:0]         signal_shape,
  output logic               param_upd
);

  localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

  localparam logic [PHASE_W:0]   LP_PH_STEP = (PHASE_W+1)'(PHASE_STEP);
  localparam logic [PHASE_W:0]   LP_PH_MAX  = {1'b0, {PHASE_W{1'b1}}};
  localparam logic [PHASE_W:0]   LP_SW_MIN  = (PHASE_W+1)'(SWEEP_MIN);
  localparam logic [PHASE_W:0]   LP_SW_MAX  = (PHASE_W+1)'(SWEEP_MAX);
  localparam logic [PHASE_W-1:0] LP_PH_INIT = PHASE_W'(PHASE_INIT);
  localparam logic [PHASE_W-1:0] LP_PH_ONE  = PHASE_W'(1);
  localparam logic [AMP_W:0]     LP_AMP_STEP = (AMP_W+1)'(AMP_STEP);
  localparam logic [AMP_W:0]     LP_AMP_MAX  = (AMP_W+1)'(AMP_MAX);
  localparam logic [AMP_W-1:0]   LP_AMP_INIT = AMP_W'(AMP_INIT);
  localparam logic [DIV_W-1:0]   LP_DIV_TC   = DIV_W'(SWEEP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN} state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic [PHASE_W-1:0] r_stg_phase, r_phase_M;
  logic [AMP_W-1:0]   r_stg_amp, r_signal_A;
  logic [1:0]         r_stg_shape, r_signal_shape;
  logic               r_param_upd;

  logic [PHASE_W:0]   w_ph_ext, w_ph_inc, w_ph_dec;
  logic [PHASE_W-1:0] w_man_up, w_man_dn, w_sw_up, w_sw_dn, w_sw_phase;
  logic [AMP_W:0]     w_amp_ext, w_amp_inc;
  logic [AMP_W-1:0]   w_amp_up, w_amp_dn;
  logic               w_sw_tick, w_sw_step, w_commit, w_diff;

  // Widened step arithmetic so saturation compares cannot overflow
  always_comb begin
    w_ph_ext  = {1'b0, r_stg_phase};
    w_ph_inc  = w_ph_ext + LP_PH_STEP;
    w_ph_dec  = w_ph_ext - LP_PH_STEP;
    w_man_up  = (w_ph_inc > LP_PH_MAX) ? LP_PH_MAX[PHASE_W-1:0] : w_ph_inc[PHASE_W-1:0];
    w_man_dn  = (w_ph_ext > LP_PH_STEP) ? w_ph_dec[PHASE_W-1:0] : LP_PH_ONE;
    // Sweep steps also pull an out-of-range start back inside [MIN, MAX]
    if (w_ph_inc >= LP_SW_MAX)     w_sw_up = LP_SW_MAX[PHASE_W-1:0];
    else if (w_ph_inc < LP_SW_MIN) w_sw_up = LP_SW_MIN[PHASE_W-1:0];
    else                           w_sw_up = w_ph_inc[PHASE_W-1:0];
    if ((w_ph_ext <= LP_PH_STEP) || (w_ph_dec <= LP_SW_MIN)) w_sw_dn = LP_SW_MIN[PHASE_W-1:0];
    else if (w_ph_dec > LP_SW_MAX)                           w_sw_dn = LP_SW_MAX[PHASE_W-1:0];
    else                                                     w_sw_dn = w_ph_dec[PHASE_W-1:0];
    w_amp_ext = {1'b0, r_stg_amp};
    w_amp_inc = w_amp_ext + LP_AMP_STEP;
    w_amp_up  = (w_amp_inc > LP_AMP_MAX) ? LP_AMP_MAX[AMP_W-1:0] : w_amp_inc[AMP_W-1:0];
    w_amp_dn  = (w_amp_ext < LP_AMP_STEP) ? '0 : r_stg_amp - LP_AMP_STEP[AMP_W-1:0];
  end

  // Sweep FSM next state and the phase value of a sweep step
  always_comb begin
    w_state_nxt = r_state;
    w_sw_phase  = r_stg_phase;
    w_sw_tick   = (r_state != S_IDLE) && (r_div == LP_DIV_TC);
    w_sw_step   = w_sw_tick && sweep_en;
    case (r_state)
      S_IDLE: if (sweep_en) w_state_nxt = S_UP;
      S_UP: begin
        if (!sweep_en) w_state_nxt = S_IDLE;
        else if (w_sw_tick) begin
          w_sw_phase = w_sw_up;
          if ({1'b0, w_sw_up} == LP_SW_MAX) w_state_nxt = S_DN;
        end
      end
      S_DN: begin
        if (!sweep_en) w_state_nxt = S_IDLE;
        else if (w_sw_tick) begin
          w_sw_phase = w_sw_dn;
          if ({1'b0, w_sw_dn} == LP_SW_MIN) w_state_nxt = S_UP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state and sweep divider; divider only runs while sweeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!sweep_en || r_state == S_IDLE || r_div == LP_DIV_TC) r_div <= '0;
      else                                                    r_div <= r_div + 1'b1;
    end
  end

  // Staged parameters: manual phase steps only while the sweep is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg_phase <= LP_PH_INIT;
      r_stg_amp   <= LP_AMP_INIT;
      r_stg_shape <= 2'd0;
    end else begin
      if (r_state == S_IDLE) begin
        if (freq_up && !freq_dn)      r_stg_phase <= w_man_up;
        else if (freq_dn && !freq_up) r_stg_phase <= w_man_dn;
      end else if (w_sw_step) begin
        r_stg_phase <= w_sw_phase;
      end
      if (amp_up && !amp_dn)      r_stg_amp <= w_amp_up;
      else if (amp_dn && !amp_up) r_stg_amp <= w_amp_dn;
      if (shape_next) r_stg_shape <= (r_stg_shape >= 2'd2) ? 2'd0 : r_stg_shape + 2'd1;
    end
  end

  assign w_commit = (SYNC_UPDATE != 0) ? phase_wrap : 1'b1;
  assign w_diff   = (r_stg_phase != r_phase_M) || (r_stg_amp != r_signal_A) ||
                    (r_stg_shape != r_signal_shape);

  // Commit staged values to the outputs; flag commits that changed something
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase_M      <= LP_PH_INIT;
      r_signal_A     <= LP_AMP_INIT;
      r_signal_shape <= 2'd0;
      r_param_upd    <= 1'b0;
    end else begin
      r_param_upd <= w_commit && w_diff;
      if (w_commit) begin
        r_phase_M      <= r_stg_phase;
        r_signal_A     <= r_stg_amp;
        r_signal_shape <= r_stg_shape;
      end
    end
  end

  assign phase_M      = r_phase_M;
  assign signal_A     = r_signal_A;
  assign signal_shape = r_signal_shape;
  assign param_upd    = r_param_upd;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Scoreboard bench: two instances (wrap-synchronous defaults, and a
// free-running-commit instance with a small sweep window).
module tb_dds_param_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] ph;
    logic [10:0] amp;
    logic [1:0]  shp;
  } exp_t;

  exp_t q_s[$];
  exp_t q_a[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic s_fu, s_fd, s_au, s_ad, s_sn, s_sw, s_wr;
  logic [12:0] s_phase;
  logic [10:0] s_amp;
  logic [1:0]  s_shape;
  logic        s_upd;

  logic a_fu, a_fd, a_au, a_ad, a_sn, a_sw, a_wr;
  logic [12:0] a_phase;
  logic [10:0] a_amp;
  logic [1:0]  a_shape;
  logic        a_upd;

  dds_param_ctrl u_sync (
    .clk(clk), .rst(rst), .freq_up(s_fu), .freq_dn(s_fd), .amp_up(s_au),
    .amp_dn(s_ad), .shape_next(s_sn), .sweep_en(s_sw), .phase_wrap(s_wr),
    .phase_M(s_phase), .signal_A(s_amp), .signal_shape(s_shape), .param_upd(s_upd)
  );

  dds_param_ctrl #(
    .PHASE_INIT(100), .SWEEP_MIN(100), .SWEEP_MAX(130), .SWEEP_DIV(4), .SYNC_UPDATE(0)
  ) u_async (
    .clk(clk), .rst(rst), .freq_up(a_fu), .freq_dn(a_fd), .amp_up(a_au),
    .amp_dn(a_ad), .shape_next(a_sn), .sweep_en(a_sw), .phase_wrap(a_wr),
    .phase_M(a_phase), .signal_A(a_amp), .signal_shape(a_shape), .param_upd(a_upd)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_s(input int ph, input int amp, input int shp);
    q_s.push_back(exp_t'{ph[12:0], amp[10:0], shp[1:0]});
  endtask

  task automatic push_a(input int ph, input int amp, input int shp);
    q_a.push_back(exp_t'{ph[12:0], amp[10:0], shp[1:0]});
  endtask

  task automatic wrap_s();
    s_wr = 1'b1; tick(); s_wr = 1'b0;
  endtask

  // Monitor: every param_upd pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (s_upd) begin
      if (q_s.size() == 0) chk("s_upd_unexpected", 1, 0);
      else begin
        e = q_s.pop_front();
        chk("s_upd_phase", s_phase, e.ph);
        chk("s_upd_amp", s_amp, e.amp);
        chk("s_upd_shape", s_shape, e.shp);
      end
    end
    if (a_upd) begin
      if (q_a.size() == 0) chk("a_upd_unexpected", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_upd_phase", a_phase, e.ph);
        chk("a_upd_amp", a_amp, e.amp);
        chk("a_upd_shape", a_shape, e.shp);
      end
    end
  end

  initial begin
    {s_fu, s_fd, s_au, s_ad, s_sn, s_sw, s_wr} = '0;
    {a_fu, a_fd, a_au, a_ad, a_sn, a_sw, a_wr} = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("rst_s_phase", s_phase, 500);
    chk("rst_s_amp", s_amp, 1200);
    chk("rst_s_shape", s_shape, 0);
    chk("rst_s_upd", s_upd, 0);
    chk("rst_a_phase", a_phase, 100);
    chk("rst_a_upd", a_upd, 0);
    tick(3);
    chk("s_hold_no_wrap", s_phase, 500);

    // wrap-synchronous commit
    s_fu = 1'b1; tick(3); s_fu = 1'b0;
    tick(2);
    chk("s_staged_not_visible", s_phase, 500);
    push_s(530, 1200, 0);
    wrap_s();
    chk("s_commit_530", s_phase, 530);
    tick(2);
    s_fu = 1'b1; s_wr = 1'b1; tick(); s_fu = 1'b0; s_wr = 1'b0;
    chk("s_coincident_wrap", s_phase, 530);
    tick(2);
    chk("s_wait_next_wrap", s_phase, 530);
    push_s(540, 1200, 0);
    wrap_s();
    chk("s_commit_540", s_phase, 540);
    s_wr = 1'b1; tick(3); s_wr = 1'b0;   // back-to-back wraps, nothing changed

    // amplitude saturation
    s_au = 1'b1; tick(20); s_au = 1'b0;
    push_s(540, 2047, 0);
    wrap_s();
    chk("s_amp_ceiling", s_amp, 2047);
    s_ad = 1'b1; tick(50); s_ad = 1'b0;
    push_s(540, 0, 0);
    wrap_s();
    chk("s_amp_floor", s_amp, 0);

    // opposing pulses cancel
    {s_fu, s_fd, s_au, s_ad} = 4'hF; tick(); {s_fu, s_fd, s_au, s_ad} = 4'h0;
    wrap_s();
    tick(2);
    chk("s_cancel_phase", s_phase, 540);
    chk("s_cancel_amp", s_amp, 0);

    // phase ceiling
    s_fu = 1'b1; tick(800); s_fu = 1'b0;
    push_s(8191, 0, 0);
    wrap_s();
    chk("s_phase_ceiling", s_phase, 8191);

    // shape cycling on the free-running instance
    for (int i = 0; i < 4; i++) begin
      push_a(100, 1200, (i + 1) % 3);
      a_sn = 1'b1; a_wr = 1'b1; tick(); a_sn = 1'b0; a_wr = 1'b0;
      tick(2);
      chk("a_shape_cycle", a_shape, (i + 1) % 3);
    end

    // triangular sweep 100..130, step 10 every 4 cycles
    push_a(110, 1200, 1); push_a(120, 1200, 1); push_a(130, 1200, 1); push_a(120, 1200, 1);
    push_a(110, 1200, 1); push_a(100, 1200, 1); push_a(110, 1200, 1); push_a(120, 1200, 1);
    a_sw = 1'b1; tick();            // edge e0 samples sweep_en
    tick(4);
    chk("a_sweep_first_not_early", a_phase, 100);
    tick();
    chk("a_sweep_first_step", a_phase, 110);
    tick(5);
    a_fu = 1'b1; tick(); a_fu = 1'b0;   // ignored while sweeping
    tick(21);                            // just after e0+32: staged 120
    a_sw = 1'b0;
    tick(10);
    chk("a_sweep_hold_120", a_phase, 120);

    // back in IDLE: manual steps act again
    push_a(130, 1200, 1);
    a_fu = 1'b1; tick(); a_fu = 1'b0;
    tick(2);
    chk("a_idle_manual_up", a_phase, 130);
    push_a(120, 1200, 1);
    a_fd = 1'b1; tick(); a_fd = 1'b0;
    tick(2);

    // reset mid-sweep with a pending step in SWP_DN
    push_a(130, 1200, 1);
    a_sw = 1'b1; tick();
    tick(8);                        // staged 120 on the way down, output 130
    chk("a_pre_reset_out", a_phase, 130);
    rst = 1'b1; tick(2); rst = 1'b0;
    chk("a_rst_phase", a_phase, 100);
    chk("a_rst_amp", a_amp, 1200);
    chk("a_rst_shape", a_shape, 0);
    chk("s_rst_again_phase", s_phase, 500);
    push_a(110, 1200, 0);
    tick(5);
    chk("a_restart_not_early", a_phase, 100);
    tick();
    chk("a_restart_first_step", a_phase, 110);
    a_sw = 1'b0;
    tick(3);

    // phase floor at 1
    for (int v = 100; v >= 10; v -= 10) push_a(v, 1200, 0);
    push_a(1, 1200, 0);
    a_fd = 1'b1; tick(12); a_fd = 1'b0;
    tick(3);
    chk("a_phase_floor", a_phase, 1);
    {a_fu, a_fd} = 2'b11; tick(); {a_fu, a_fd} = 2'b00;
    tick(3);
    chk("a_cancel_phase", a_phase, 1);

    tick(5);
    chk("s_queue_drained", q_s.size(), 0);
    chk("a_queue_drained", q_a.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
